// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares a single sign-magnitude Q7.8 multiplier among NREQ requesters.
//   A round-robin arbiter grants one requester per clock. The granted operands
//   pass through an operand register (stage 1) and then a result register
//   (stage 2). The result is broadcast with the index of the requester that
//   owns it. There is no backpressure, so throughput is one multiply per clock.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst            : synchronous active-high reset
//   req_valid[i]   : requester i has an operand pair pending
//   req_a / req_b  : operands, requester i in bits [N*i +: N]
//   gnt            : one-hot or zero; gnt[i] means requester i is taken at this edge
//   resp_valid     : single-cycle pulse, result register holds a new product
//   resp_id        : index of the requester that owns resp_c
//   resp_c         : product (bits [31:16] always zero)
//   resp_cout, resp_zero, resp_overflow, resp_neg : flags of that product
//   mul_count      : results delivered since reset, wraps at 2^32
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int N    = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  output logic [NREQ-1:0]     gnt,
  output logic                resp_valid,
  output logic [IDW-1:0]      resp_id,
  output logic [N-1:0]        resp_c,
  output logic                resp_cout,
  output logic                resp_zero,
  output logic                resp_overflow,
  output logic                resp_neg,
  output logic [31:0]         mul_count
);

  // Only the low 16 bits of each operand take part in the Q7.8 arithmetic.
  localparam int QW = 16;

  logic [QW-1:0]   op_a [NREQ];
  logic [QW-1:0]   op_b [NREQ];
  logic [NREQ-1:0] upper_par;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_a[gi] = req_a[N*gi +: QW];
      assign op_b[gi] = req_b[N*gi +: QW];
      if (N > QW) begin : g_upper
        // The upper operand bits are ignored; they are folded into a parity
        // that goes nowhere, only so that they count as read.
        assign upper_par[gi] = ^{req_a[N*gi+QW +: N-QW], req_b[N*gi+QW +: N-QW]};
      end else begin : g_no_upper
        assign upper_par[gi] = 1'b0;
      end
    end
  endgenerate

  // State
  logic [IDW-1:0] rr_ptr_q,     rr_ptr_d;
  logic           s1_valid_q,   s1_valid_d;
  logic [IDW-1:0] s1_id_q,      s1_id_d;
  logic [QW-1:0]  s1_a_q,       s1_a_d;
  logic [QW-1:0]  s1_b_q,       s1_b_d;
  logic           resp_valid_q, resp_valid_d;
  logic [IDW-1:0] resp_id_q,    resp_id_d;
  logic [N-1:0]   resp_c_q,     resp_c_d;
  logic           resp_cout_q,  resp_cout_d;
  logic           resp_zero_q,  resp_zero_d;
  logic           resp_neg_q,   resp_neg_d;
  logic [31:0]    mul_count_q,  mul_count_d;

  // Round-robin grant: scan upward from rr_ptr, wrapping at NREQ.
  logic [NREQ-1:0] gnt_d;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [IDW:0]    scan;

  always_comb begin
    gnt_d   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    scan    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
        gnt_d[scan[IDW-1:0]] = 1'b1;
        gnt_idx              = scan[IDW-1:0];
        gnt_any              = 1'b1;
      end
    end
    // Nothing is accepted while reset is held.
    if (rst) begin
      gnt_d   = '0;
      gnt_any = 1'b0;
    end
  end

  assign gnt = gnt_d;

  // Q7.8 sign-magnitude multiply on the stage-1 operands.
  logic [2*(QW-1)-1:0] prod;
  logic [QW-2:0]       res_mag;
  logic                res_sign;
  logic                res_cout;
  logic                unused_bits;

  always_comb begin
    prod     = {{(QW-1){1'b0}}, s1_a_q[QW-2:0]} * {{(QW-1){1'b0}}, s1_b_q[QW-2:0]};
    res_mag  = prod[QW-2+8:8];
    res_cout = prod[QW-1+8];
    res_sign = s1_a_q[QW-1] ^ s1_b_q[QW-1];
  end

  assign unused_bits = ^{upper_par, prod[2*(QW-1)-1:QW+8], prod[7:0]};

  // Next-state logic for both pipeline stages and the pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end

    s1_valid_d = gnt_any;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (gnt_any) begin
      s1_id_d = gnt_idx;
      s1_a_d  = op_a[gnt_idx];
      s1_b_d  = op_b[gnt_idx];
    end

    resp_valid_d = s1_valid_q;
    resp_id_d    = resp_id_q;
    resp_c_d     = resp_c_q;
    resp_cout_d  = resp_cout_q;
    resp_zero_d  = resp_zero_q;
    resp_neg_d   = resp_neg_q;
    mul_count_d  = mul_count_q;
    if (s1_valid_q) begin
      resp_id_d   = s1_id_q;
      resp_c_d    = N'({res_sign, res_mag});
      resp_cout_d = res_cout;
      // The zero flag reflects operand A only, not the product.
      resp_zero_d = (s1_a_q[QW-2:0] == '0);
      resp_neg_d  = res_sign;
      mul_count_d = mul_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_c_q     <= '0;
      resp_cout_q  <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_neg_q   <= 1'b0;
      mul_count_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_c_q     <= resp_c_d;
      resp_cout_q  <= resp_cout_d;
      resp_zero_q  <= resp_zero_d;
      resp_neg_q   <= resp_neg_d;
      mul_count_q  <= mul_count_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_c        = resp_c_q;
  assign resp_cout     = resp_cout_q;
  assign resp_zero     = resp_zero_q;
  assign resp_overflow = 1'b0;
  assign resp_neg      = resp_neg_q;
  assign mul_count     = mul_count_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Directed-vector bench for mul_share_arbiter with hand-computed results.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mul_share_arbiter;

  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*N-1:0]   req_a;
  logic [NREQ*N-1:0]   req_b;
  logic [NREQ-1:0]     gnt;
  logic                resp_valid;
  logic [IDW-1:0]      resp_id;
  logic [N-1:0]        resp_c;
  logic                resp_cout;
  logic                resp_zero;
  logic                resp_overflow;
  logic                resp_neg;
  logic [31:0]         mul_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NREQ(NREQ), .N(N), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_a         (req_a),
    .req_b         (req_b),
    .gnt           (gnt),
    .resp_valid    (resp_valid),
    .resp_id       (resp_id),
    .resp_c        (resp_c),
    .resp_cout     (resp_cout),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow),
    .resp_neg      (resp_neg),
    .mul_count     (mul_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[N*i +: N] = a;
    req_b[N*i +: N] = b;
  endtask

  // One isolated operation: grant in cycle k, nothing in k+1, result in k+2.
  task automatic single(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_c, input logic exp_cout,
                        input logic exp_zero, input logic exp_neg,
                        input logic [31:0] exp_cnt);
    @(negedge clk);
    set_op(i, a, b);
    req_valid = 4'(1 << i);
    #1;
    chk("single_gnt", 64'(gnt), 64'(1 << i));
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("single_rv_k1", 64'(resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("single_rv", 64'(resp_valid), 64'd1);
    chk("single_id", 64'(resp_id), 64'(i));
    chk("single_c", 64'(resp_c), 64'(exp_c));
    chk("single_cout", 64'(resp_cout), 64'(exp_cout));
    chk("single_zero", 64'(resp_zero), 64'(exp_zero));
    chk("single_ovf", 64'(resp_overflow), 64'd0);
    chk("single_neg", 64'(resp_neg), 64'(exp_neg));
    chk("single_cnt", 64'(mul_count), 64'(exp_cnt));
    $display("txn req%0d a=0x%08h b=0x%08h -> c=0x%08h cout=%0b zero=%0b neg=%0b cnt=%0d",
             i, a, b, resp_c, resp_cout, resp_zero, resp_neg, mul_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(posedge clk);

    // Reset state; requests during reset must not be granted.
    @(negedge clk);
    req_valid = '1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_cnt", 64'(mul_count), 64'd0);
    chk("rst_c", 64'(resp_c), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    @(negedge clk);
    req_valid = '0;
    rst       = 1'b0;

    // Isolated operations with hand-computed Q7.8 results.
    single(0, 32'h0000_0200, 32'h0000_0180, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'd1);
    single(1, 32'h0000_8200, 32'h0000_0180, 32'h0000_8300, 1'b0, 1'b0, 1'b1, 32'd2);
    single(2, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'd3);
    single(3, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7F00, 1'b1, 1'b0, 1'b0, 32'd4);
    single(0, 32'hABCD_7FFF, 32'hABCD_7FFF, 32'h0000_7F00, 1'b1, 1'b0, 1'b0, 32'd5);
    // Zero product from a zero B operand: the zero flag follows A, so it stays clear.
    single(1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'd6);

    // All requesters valid continuously from reset: 0,1,2,3,0,... one per cycle.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(32'h100 * (i + 1)), 32'h0000_0100);
    req_valid = '1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("cont_gnt", 64'(gnt), 64'(1 << (c % NREQ)));
      chk("cont_rv", 64'(resp_valid), (c >= 2) ? 64'd1 : 64'd0);
      chk("cont_cnt", 64'(mul_count), (c >= 2) ? 64'(c - 1) : 64'd0);
      if (c >= 2) begin
        chk("cont_id", 64'(resp_id), 64'((c - 2) % NREQ));
        chk("cont_c", 64'(resp_c), 64'(32'h100 * ((c - 2) % NREQ + 1)));
      end
      $display("txn cycle%0d gnt=%b resp_valid=%0b id=%0d c=0x%08h cnt=%0d",
               c, gnt, resp_valid, resp_id, resp_c, mul_count);
    end

    // Reset with operations in flight: they must never produce a response.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", 64'(gnt), 64'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_rv", 64'(resp_valid), 64'd0);
    chk("mid_rst_cnt", 64'(mul_count), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b1100;
    #1;
    chk("post_rst_rv0", 64'(resp_valid), 64'd0);
    chk("post_rst_gnt", 64'(gnt), 64'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("post_rst_rv1", 64'(resp_valid), 64'd0);
    @(negedge clk);
    #1;
    chk("post_rst_rv2", 64'(resp_valid), 64'd1);
    chk("post_rst_id", 64'(resp_id), 64'd2);
    chk("post_rst_c", 64'(resp_c), 64'h300);
    chk("post_rst_cnt", 64'(mul_count), 64'd1);
    $display("txn post-reset id=%0d c=0x%08h cnt=%0d", resp_id, resp_c, mul_count);

    // Fairness: req0 held valid, req2 joins in cycle 3 and is served at once.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("fair_gnt0", 64'(gnt), 64'b0001);
    end
    @(negedge clk);
    req_valid = 4'b0101;
    #1;
    chk("fair_gnt2", 64'(gnt), 64'b0100);
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    @(negedge clk);
    #1;
    chk("fair_gnt_back", 64'(gnt), 64'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("fair_cnt", 64'(mul_count), 64'd5);
    $display("txn fairness cnt=%0d", mul_count);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one instance of the existing multiplyUnit (N=32) among NREQ requesters, for example core execution lanes. Arbitration is round-robin with a valid/grant handshake. Accepted operands pass through a 2-stage registered pipeline (operand register, then result register). Results are broadcast with the requester index; throughput is one multiply per clock.

Parameters:
NREQ, 4, number of requesters (2..8)
N, 32, operand/result width passed to multiplyUnit
IDW, $clog2(NREQ), width of the requester index

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NREQ  bit i = requester i has an operand pair pending
req_a  in  NREQ*N  operand A of requester i in bits [N*i+N-1:N*i]
req_b  in  NREQ*N  operand B, same slicing
gnt  out  NREQ  one-hot or zero; gnt[i]=1 means requester i is accepted at this edge
resp_valid  out  1  result register holds a new result (single-cycle pulse per operation)
resp_id  out  IDW  index of the requester owning the result
resp_c  out  N  product
resp_cout, resp_zero, resp_overflow, resp_neg  out  1 each  flags of that product
mul_count  out  32  number of results delivered since reset, wraps at 2^32

Behaviour:
- Reset: when rst=1 at an edge:
  - rr_ptr <= 0.
  - s1_valid, resp_valid <= 0; resp_id, resp_c and all flags <= 0; mul_count <= 0.
  - In-flight operations are discarded; no response is issued for them.
  - gnt is forced to 0 while rst=1.
- Grant (combinational, same cycle as request):
  - Search starts at rr_ptr and moves upward, wrapping modulo NREQ. The first i with req_valid[i]=1 gets gnt[i]=1.
  - No requester valid: gnt=0 and rr_ptr holds.
  - After a grant to i: rr_ptr <= (i+1) mod NREQ.
  - At most one gnt bit is set per cycle.
- Requester rules:
  - Hold req_valid and operands stable until gnt is seen.
  - Deasserting req_valid before grant (withdrawal) is legal and produces no response.
  - Back-to-back requests from the same requester are legal; that requester competes again through round-robin.
- Stage 1, at the grant edge: s1_valid <= |gnt; s1_id <= granted index; s1_a/s1_b <= granted operands. The stage always advances; there is no backpressure.
- Stage 2, the next edge:
  - resp_valid <= s1_valid; resp_id <= s1_id.
  - resp_c and flags <= multiplyUnit(s1_a, s1_b) outputs.
  - mul_count increments when s1_valid=1.
  - When s1_valid=0, resp_valid <= 0 and data registers hold.
- Latency: grant in cycle k, response visible in cycle k+2. Continuous requests give 1 result per cycle.
- Arithmetic, sign-magnitude Q7.8 in bits [15:0]:
  - c[15] = a[15]^b[15].
  - c[14:0] = ((a[14:0]*b[14:0])>>8)[14:0].
  - c[31:16] = 0.
  - Operand bits [31:16] are ignored.
- Flags:
  - cout = bit 15 of the shifted product.
  - zero = (a[14:0]==0); it depends on operand A only.
  - overflow = 0.
  - neg = c[15].
- Simultaneous events: a response for one operation and a grant for the next may occur in the same cycle; both are required.
- A reset arriving between grant and response cancels that response.

Test Plan:
- Single request, req0 a=0x0200, b=0x0180 -> gnt[0] in cycle k; cycle k+2: resp_valid=1, id=0, c=0x00000300, neg=0, zero=0, cout=0; mul_count=1.
- req1 a=0x8200, b=0x0180 -> c=0x00008300, neg=1. req2 a=0x0000, b=0x1234 -> c=0, zero=1.
- req3 a=0x7FFF, b=0x7FFF -> c=0x00007F00, cout=1, neg=0, overflow=0. Upper operand bits 0xABCD0000 set -> same result.
- All 4 requesters valid continuously from reset -> gnt order 0,1,2,3,0,... one per cycle; resp_id sequence matches two cycles later; mul_count increments every cycle.
- Fairness: req0 held valid, req2 asserted in cycle 3 -> req2 granted no later than the second grant after its assertion; req0 never starves req2.
- Reset while 2 operations are in flight -> no resp_valid afterwards, mul_count=0, rr_ptr=0. First post-reset grant goes to the lowest valid index.
